// File: rtl/fwpayload_wb_arbiter.sv
// Two-initiator, one-target Wishbone classic arbiter. Grants are round-robin
// and held for a whole bus cycle, and a watchdog ends stalled transfers with err.
module fwpayload_wb_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  // initiator 0: management SoC
  input  logic                    m0_cyc,
  input  logic                    m0_stb,
  input  logic                    m0_we,
  input  logic [DATA_WIDTH/8-1:0] m0_sel,
  input  logic [ADDR_WIDTH-1:0]   m0_adr,
  input  logic [DATA_WIDTH-1:0]   m0_dat_w,
  output logic [DATA_WIDTH-1:0]   m0_dat_r,
  output logic                    m0_ack,
  output logic                    m0_err,
  // initiator 1: logic-analyzer debug path
  input  logic                    m1_cyc,
  input  logic                    m1_stb,
  input  logic                    m1_we,
  input  logic [DATA_WIDTH/8-1:0] m1_sel,
  input  logic [ADDR_WIDTH-1:0]   m1_adr,
  input  logic [DATA_WIDTH-1:0]   m1_dat_w,
  output logic [DATA_WIDTH-1:0]   m1_dat_r,
  output logic                    m1_ack,
  output logic                    m1_err,
  // shared target
  output logic                    t_cyc,
  output logic                    t_stb,
  output logic                    t_we,
  output logic [DATA_WIDTH/8-1:0] t_sel,
  output logic [ADDR_WIDTH-1:0]   t_adr,
  output logic [DATA_WIDTH-1:0]   t_dat_w,
  input  logic [DATA_WIDTH-1:0]   t_dat_r,
  input  logic                    t_ack,
  // status
  output logic [1:0]              grant,
  output logic                    timeout_evt
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int WD_WIDTH  = $clog2(TIMEOUT + 1);
  localparam logic [WD_WIDTH-1:0] WD_LAST = WD_WIDTH'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t                state_q, state_next;
  logic [1:0]            grant_q, grant_next;
  logic                  last_q, last_next;
  logic [WD_WIDTH-1:0]   wd_cnt_q, wd_cnt_next;

  // Owner's request, selected by the registered one-hot grant.
  logic                  own_cyc, own_stb, own_we;
  logic [SEL_WIDTH-1:0]  own_sel;
  logic [ADDR_WIDTH-1:0] own_adr;
  logic [DATA_WIDTH-1:0] own_dat_w;

  always_comb begin
    own_cyc   = 1'b0;
    own_stb   = 1'b0;
    own_we    = 1'b0;
    own_sel   = '0;
    own_adr   = '0;
    own_dat_w = '0;
    if (grant_q[0]) begin
      own_cyc   = m0_cyc;
      own_stb   = m0_stb;
      own_we    = m0_we;
      own_sel   = m0_sel;
      own_adr   = m0_adr;
      own_dat_w = m0_dat_w;
    end else if (grant_q[1]) begin
      own_cyc   = m1_cyc;
      own_stb   = m1_stb;
      own_we    = m1_we;
      own_sel   = m1_sel;
      own_adr   = m1_adr;
      own_dat_w = m1_dat_w;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= 2'b00;
      last_q   <= 1'b1;
      wd_cnt_q <= '0;
    end else begin
      state_q  <= state_next;
      grant_q  <= grant_next;
      last_q   <= last_next;
      wd_cnt_q <= wd_cnt_next;
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_next  = state_q;
    grant_next  = grant_q;
    last_next   = last_q;
    wd_cnt_next = wd_cnt_q;
    unique case (state_q)
      IDLE: begin
        wd_cnt_next = '0;
        // On a tie the initiator that was not served last wins.
        if (m0_cyc && (!m1_cyc || last_q)) begin
          grant_next = 2'b01;
          last_next  = 1'b0;
          state_next = BUSY;
        end else if (m1_cyc) begin
          grant_next = 2'b10;
          last_next  = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (!own_cyc) begin
          state_next  = IDLE;
          grant_next  = 2'b00;
          wd_cnt_next = '0;
        end else if (own_stb && !t_ack) begin
          // Expiry leaves the counter at its last value, so it never wraps.
          if (wd_cnt_q == WD_LAST) state_next = ERR;
          else                     wd_cnt_next = wd_cnt_q + WD_WIDTH'(1);
        end else begin
          wd_cnt_next = '0;
        end
      end
      ERR: begin
        state_next  = IDLE;
        grant_next  = 2'b00;
        wd_cnt_next = '0;
      end
      default: begin
        state_next  = IDLE;
        grant_next  = 2'b00;
        wd_cnt_next = '0;
      end
    endcase
  end

  always_comb begin
    t_cyc       = 1'b0;
    t_stb       = 1'b0;
    t_we        = 1'b0;
    t_sel       = '0;
    t_adr       = '0;
    t_dat_w     = '0;
    m0_ack      = 1'b0;
    m1_ack      = 1'b0;
    m0_err      = 1'b0;
    m1_err      = 1'b0;
    timeout_evt = 1'b0;
    if (state_q == BUSY) begin
      t_cyc   = own_cyc;
      t_stb   = own_stb;
      t_we    = own_we;
      t_sel   = own_sel;
      t_adr   = own_adr;
      t_dat_w = own_dat_w;
      m0_ack  = t_ack & grant_q[0];
      m1_ack  = t_ack & grant_q[1];
    end else if (state_q == ERR) begin
      // Target is released and t_ack is ignored; only the owner sees err.
      m0_err      = grant_q[0];
      m1_err      = grant_q[1];
      timeout_evt = 1'b1;
    end
  end

  assign m0_dat_r = t_dat_r;
  assign m1_dat_r = t_dat_r;
  assign grant    = grant_q;

endmodule

// File: tb/tb_fwpayload_wb_arbiter.sv
// Self-checking bench for fwpayload_wb_arbiter: arbitration vector table plus
// directed sequences for write, read, fairness, timeout, burst lock and reset.
module tb_fwpayload_wb_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic          clock, reset;
  logic          m0_cyc, m0_stb, m0_we, m0_ack, m0_err;
  logic [SW-1:0] m0_sel;
  logic [AW-1:0] m0_adr;
  logic [DW-1:0] m0_dat_w, m0_dat_r;
  logic          m1_cyc, m1_stb, m1_we, m1_ack, m1_err;
  logic [SW-1:0] m1_sel;
  logic [AW-1:0] m1_adr;
  logic [DW-1:0] m1_dat_w, m1_dat_r;
  logic          t_cyc, t_stb, t_we, t_ack;
  logic [SW-1:0] t_sel;
  logic [AW-1:0] t_adr;
  logic [DW-1:0] t_dat_w, t_dat_r;
  logic [1:0]    grant;
  logic          timeout_evt;

  fwpayload_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_sel(m0_sel),
    .m0_adr(m0_adr), .m0_dat_w(m0_dat_w), .m0_dat_r(m0_dat_r),
    .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_sel(m1_sel),
    .m1_adr(m1_adr), .m1_dat_w(m1_dat_w), .m1_dat_r(m1_dat_r),
    .m1_ack(m1_ack), .m1_err(m1_err),
    .t_cyc(t_cyc), .t_stb(t_stb), .t_we(t_we), .t_sel(t_sel),
    .t_adr(t_adr), .t_dat_w(t_dat_w), .t_dat_r(t_dat_r), .t_ack(t_ack),
    .grant(grant), .timeout_evt(timeout_evt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       m0;
    logic       m1;
    logic [1:0] exp_grant;
  } arb_vec_t;

  arb_vec_t    vecs[9];
  logic [1:0]  grant_q[$];
  logic [31:0] data_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_sel = '0; m0_adr = '0; m0_dat_w = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = '0; m1_adr = '0; m1_dat_w = '0;
    t_ack = 0; t_dat_r = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  prev_g;
    logic [1:0]  exp_g;
    logic [31:0] exp_d;
    logic        drop0, drop1;
    int          done;

    // ---------------- reset state ----------------
    do_reset();
    check("rst_grant", grant, 2'b00);
    check("rst_t_cyc", t_cyc, 0);
    check("rst_t_adr", t_adr, 0);
    check("rst_acks", {m0_ack, m1_ack, m0_err, m1_err, timeout_evt}, 0);

    // ---------------- single write ----------------
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_sel = 4'hF;
    m0_adr = 32'h3000_0000; m0_dat_w = 32'hDEAD_BEEF;
    #1;
    check("wr_N_grant", grant, 2'b00);
    step();  // N+1
    check("wr_grant", grant, 2'b01);
    check("wr_t_cyc_stb", {t_cyc, t_stb, t_we}, 3'b111);
    check("wr_t_adr", t_adr, 32'h3000_0000);
    check("wr_t_dat", t_dat_w, 32'hDEAD_BEEF);
    check("wr_t_sel", t_sel, 4'hF);
    step();  // N+2
    t_ack = 1;
    #1;
    check("wr_m0_ack", m0_ack, 1);
    check("wr_m1_ack", m1_ack, 0);
    check("wr_m0_err", m0_err, 0);
    step();  // N+3
    t_ack = 0; m0_cyc = 0; m0_stb = 0; m0_we = 0;
    #1;
    check("wr_t_cyc_drop", t_cyc, 0);
    check("wr_grant_hold", grant, 2'b01);
    step();  // N+4
    check("wr_grant_release", grant, 2'b00);

    // ---------------- tie after reset, read ----------------
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0010;
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_0020;
    step();
    check("tie_grant_m0", grant, 2'b01);
    check("tie_t_adr_m0", t_adr, 32'h10);
    t_ack = 1; t_dat_r = 32'h1234_5678;
    #1;
    check("rd_m0_ack", m0_ack, 1);
    check("rd_m0_data", m0_dat_r, 32'h1234_5678);
    check("rd_m1_ack", m1_ack, 0);
    step();  // R
    t_ack = 0; m0_cyc = 0; m0_stb = 0;
    #1;
    check("tie_R_t_cyc", t_cyc, 0);
    step();  // R+1
    check("tie_R1_grant", grant, 2'b00);
    step();  // R+2
    check("tie_R2_grant_m1", grant, 2'b10);
    check("tie_t_adr_m1", t_adr, 32'h20);
    t_ack = 1; t_dat_r = 32'hCAFE_F00D;
    #1;
    check("rd_m1_ack", m1_ack, 1);
    check("rd_m1_data", m1_dat_r, 32'hCAFE_F00D);
    check("rd_m0_no_ack", m0_ack, 0);
    step();
    idle_inputs();
    step();
    step();

    // ---------------- arbitration vector table ----------------
    vecs[0] = '{1'b1, 1'b0, 2'b01};
    vecs[1] = '{1'b0, 1'b1, 2'b10};
    vecs[2] = '{1'b1, 1'b1, 2'b01};
    vecs[3] = '{1'b1, 1'b1, 2'b10};
    vecs[4] = '{1'b0, 1'b0, 2'b00};
    vecs[5] = '{1'b1, 1'b1, 2'b01};
    vecs[6] = '{1'b0, 1'b1, 2'b10};
    vecs[7] = '{1'b1, 1'b0, 2'b01};
    vecs[8] = '{1'b0, 1'b1, 2'b10};
    for (int i = 0; i < 9; i++) begin
      m0_cyc = vecs[i].m0;
      m1_cyc = vecs[i].m1;
      step();
      check($sformatf("vec%0d_grant", i), grant, vecs[i].exp_grant);
      check($sformatf("vec%0d_t_cyc", i), t_cyc, vecs[i].exp_grant != 2'b00);
      m0_cyc = 0; m1_cyc = 0;
      step();
    end

    // ---------------- fairness (scoreboard of grants) ----------------
    grant_q.push_back(2'b01);
    grant_q.push_back(2'b10);
    grant_q.push_back(2'b01);
    grant_q.push_back(2'b10);
    drop0 = 0; drop1 = 0; done = 0; prev_g = 2'b00;
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    for (int c = 0; c < 60 && done < 4; c++) begin
      step();
      t_ack = 0;
      m0_cyc = ~drop0; m0_stb = ~drop0;
      m1_cyc = ~drop1; m1_stb = ~drop1;
      drop0 = 0; drop1 = 0;
      #1;
      if (grant != 2'b00 && prev_g == 2'b00) begin
        if (grant_q.size() > 0) begin
          exp_g = grant_q.pop_front();
          check($sformatf("fair_grant%0d", done), grant, exp_g);
        end
        done++;
      end
      prev_g = grant;
      if (t_stb) begin
        t_ack = 1;
        #1;
        if (m0_ack) drop0 = 1;
        if (m1_ack) drop1 = 1;
      end
    end
    check("fair_transfers", done, 4);
    idle_inputs();
    step();
    step();
    step();

    // ---------------- timeout ----------------
    m1_cyc = 1; m1_stb = 1; m1_adr = 32'h40;
    step();  // G
    check("to_grant_m1", grant, 2'b10);
    for (int k = 1; k <= TO - 1; k++) step();  // G+15
    check("to_G15_noerr", {m1_err, timeout_evt}, 2'b00);
    check("to_G15_t_cyc", t_cyc, 1);
    step();  // G+16
    check("to_m1_err", m1_err, 1);
    check("to_evt", timeout_evt, 1);
    check("to_t_cyc", {t_cyc, t_stb}, 2'b00);
    check("to_no_ack_m0err", {m1_ack, m0_err, m0_ack}, 3'b000);
    m1_cyc = 0; m1_stb = 0;
    step();  // G+17
    check("to_grant_release", grant, 2'b00);
    check("to_err_one_cycle", {m1_err, timeout_evt}, 2'b00);

    // ack on the expiry cycle wins
    m1_cyc = 1; m1_stb = 1;
    step();  // G
    check("to2_grant_m1", grant, 2'b10);
    for (int k = 1; k <= TO - 1; k++) step();  // G+15
    t_ack = 1;
    #1;
    check("to2_ack_wins", {m1_ack, m1_err, timeout_evt}, 3'b100);
    step();  // G+16
    t_ack = 0;
    #1;
    check("to2_no_err", {m1_err, timeout_evt}, 2'b00);
    check("to2_still_owner", grant, 2'b10);
    idle_inputs();
    step();
    step();

    // ---------------- locked burst (scoreboard of read data) ----------------
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    step();  // G
    check("burst_grant_m0", grant, 2'b01);
    for (int b = 0; b < 4; b++) begin
      t_ack = 1;
      t_dat_r = 32'hA000_0000 + 32'(b);
      data_q.push_back(32'hA000_0000 + 32'(b));
      #1;
      check($sformatf("burst%0d_grant", b), grant, 2'b01);
      check($sformatf("burst%0d_m1_ack", b), m1_ack, 0);
      if (m0_ack && data_q.size() > 0) begin
        exp_d = data_q.pop_front();
        check($sformatf("burst%0d_data", b), m0_dat_r, exp_d);
      end
      step();
    end
    check("burst_all_acked", data_q.size(), 0);
    t_ack = 0; m0_cyc = 0; m0_stb = 0;  // R
    step();
    check("burst_R1_grant", grant, 2'b00);
    step();
    check("burst_R2_grant_m1", grant, 2'b10);
    check("burst_m1_t_stb", t_stb, 1);

    // ---------------- reset mid-transfer ----------------
    reset = 1;
    step();
    t_ack = 1;
    #1;
    check("mrst_grant", grant, 2'b00);
    check("mrst_t_cyc", t_cyc, 0);
    check("mrst_no_ack_err", {m0_ack, m1_ack, m0_err, m1_err, timeout_evt}, 0);
    reset = 0; t_ack = 0;
    m0_cyc = 1; m0_stb = 1;
    step();
    check("mrst_tie_m0", grant, 2'b01);
    idle_inputs();
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fwpayload_wb_arbiter.md
Name: fwpayload_wb_arbiter

Overview:
Two-initiator, one-target Wishbone classic arbiter for the user project's Wishbone slave port. Initiator 0 is the management-SoC Wishbone path; initiator 1 is the logic-analyzer-driven debug path. Access is granted round-robin and held for a full bus cycle (cyc-locked). A watchdog terminates a stalled target with an error, so an initiator can never hang the shared port.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width; sel width is DATA_WIDTH/8
TIMEOUT, 255, cycles stb may wait for ack before error termination (must be >= 2)

Ports:
clock  in  1  single clock for all logic
reset  in  1  synchronous, active-high reset
m0_cyc, m0_stb, m0_we  in  1 each  initiator 0 control
m0_sel  in  DATA_WIDTH/8  initiator 0 byte select
m0_adr  in  ADDR_WIDTH  initiator 0 address
m0_dat_w  in  DATA_WIDTH  initiator 0 write data
m0_dat_r  out  DATA_WIDTH  initiator 0 read data
m0_ack, m0_err  out  1 each  initiator 0 termination
m1_*  same set and widths as m0_*  initiator 1
t_cyc, t_stb, t_we  out  1 each  target control
t_sel  out  DATA_WIDTH/8  target byte select
t_adr  out  ADDR_WIDTH  target address
t_dat_w  out  DATA_WIDTH  target write data
t_dat_r  in  DATA_WIDTH  target read data
t_ack  in  1  target acknowledge
grant  out  2  one-hot current owner; 00 = none
timeout_evt  out  1  one-cycle pulse on watchdog termination

Behaviour:
- Clock and reset: one clock, `clock`. `reset` is synchronous and active-high. Reset forces state IDLE, grant=00, wd_cnt=0 and last=1, so m0 wins the first tie.
- Outputs with no owner: t_cyc, t_stb, t_we, t_sel, t_adr and t_dat_w are 0; m*_ack, m*_err and timeout_evt are 0.
- m0_dat_r and m1_dat_r both carry t_dat_r. Initiators qualify data with ack.
- States: IDLE, BUSY, ERR (registered).
- IDLE:
  - Only m0_cyc high -> grant 01.
  - Only m1_cyc high -> grant 10.
  - Both high -> grant the initiator other than `last`.
  - Any grant -> next state BUSY; `last` <= granted index; wd_cnt <= 0.
  - Grant is registered, so a request at cycle N reaches the target at N+1.
- BUSY:
  - Target outputs combinationally mux the owner's cyc/stb/we/sel/adr/dat_w.
  - t_ack routes combinationally to the owner's ack only; the non-owner ack/err stay 0.
  - Owner cyc low -> next state IDLE; target cyc drops the same cycle via the mux.
  - Watchdog: wd_cnt increments each cycle with owner stb=1 and t_ack=0. It clears on t_ack or when stb=0. When wd_cnt == TIMEOUT-1 with stb=1 and t_ack=0, next state is ERR.
  - The counter saturates; it never wraps.
- ERR (exactly one cycle):
  - Target cyc/stb forced 0; owner err=1; timeout_evt=1; t_ack ignored.
  - Next state IDLE and grant 00.
  - The initiator must drop cyc on err.
- Same-cycle t_ack and watchdog expiry: ack wins; no error.
- An owner that keeps cyc high across many stb beats keeps the grant (locked). Fairness applies only between bus cycles.
- Re-arbitration: owner drops cyc at R, state is IDLE at R+1, new owner reaches the target at R+2.
- Reset mid-transfer: next cycle all outputs are at reset values; the in-flight transfer is abandoned with no ack and no err.
- err and ack are never asserted together to the same initiator.

Test Plan:
- Single write: after reset, m0 cyc/stb/we=1, adr=0x3000_0000, dat_w=0xDEADBEEF, sel=F at N -> t_cyc/t_stb=1 with that adr/data at N+1, grant=01; target acks at N+2 -> m0_ack=1 at N+2, m1_ack=0; m0 drops cyc at N+3 -> t_cyc=0 at N+3, grant=00 at N+4.
- Tie after reset: m0 and m1 request at N -> grant=01 at N+1. m0 completes a read returning 0x12345678 and drops cyc at R -> grant=10 at R+2, m1 read data equals the target value.
- Fairness: both initiators request continuously, each dropping cyc for one cycle after every ack -> grant sequence 01,10,01,10 over 4 transfers; no initiator served twice in a row.
- Timeout: TIMEOUT=16, target never acks, m1 owns from G -> m1_err=1 and timeout_evt=1 at G+16, t_cyc=0 that cycle, grant=00 next cycle; ack at G+15 instead -> no err.
- Locked burst: m0 holds cyc for 4 stb/ack beats while m1 requests -> grant stays 01 throughout; m1 is granted 2 cycles after m0 drops cyc.
- Reset mid-cycle: assert reset while m1 owns with stb high -> next cycle grant=00, t_cyc=0, no ack/err. After reset deasserts, a tie grants m0 first.
